// File: rtl/filter_load_ctrl_pkg.sv
// Shared definitions for the filter load sequencer. The PE configuration and the
// filter scratchpad reuse these defaults.
package filter_load_ctrl_pkg;

  localparam int FLC_DATA_W     = 16;
  localparam int FLC_SPAD_DEPTH = 24;
  localparam int FLC_ADDR_W     = 5;

  typedef enum logic [1:0] {
    FLC_IDLE   = 2'd0,
    FLC_LOAD   = 2'd1,
    FLC_LOADED = 2'd2
  } flc_state_e;

  // A filter length is usable only if it is non-empty and fits in the scratchpad.
  function automatic logic flc_len_legal(input int unsigned len, input int unsigned depth);
    return (len != 0) && (len <= depth);
  endfunction

endpackage

// File: rtl/filter_load_ctrl_if.sv
// Control, input-stream and scratchpad-write signals of the filter load sequencer.
// `release` is a reserved word, so the consumer release strobe is release_in.
interface filter_load_ctrl_if
  import filter_load_ctrl_pkg::*;
#(
  parameter int DATA_W = FLC_DATA_W,
  parameter int ADDR_W = FLC_ADDR_W
);

  logic              start;
  logic [ADDR_W-1:0] filter_len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              spad_wen;
  logic [ADDR_W-1:0] spad_waddr;
  logic [DATA_W-1:0] spad_wdata;
  logic              release_in;
  logic              busy;
  logic              filter_ready;
  logic [ADDR_W-1:0] loaded_cnt;
  logic              err_len;

  modport master (
    output start, filter_len, in_valid, in_data, release_in,
    input  in_ready, spad_wen, spad_waddr, spad_wdata,
    input  busy, filter_ready, loaded_cnt, err_len
  );

  modport slave (
    input  start, filter_len, in_valid, in_data, release_in,
    output in_ready, spad_wen, spad_waddr, spad_wdata,
    output busy, filter_ready, loaded_cnt, err_len
  );

endinterface

// File: rtl/filter_load_ctrl_addr_counter.sv
// Clear/enable write-address counter with a terminal-count flag at last_idx.
// wr_ptr saturates at last_idx; loaded_cnt counts every accepted word.
module filter_addr_counter
  import filter_load_ctrl_pkg::*;
#(
  parameter int ADDR_W = FLC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] loaded_cnt,
  output logic              tc
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    tc       = (wr_ptr_q == last_idx);
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else if (en) begin
      cnt_d = cnt_q + ADDR_W'(1);
      // The final write leaves the pointer on the last address instead of wrapping.
      if (!tc) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
    end
  end

  assign wr_ptr     = wr_ptr_q;
  assign loaded_cnt = cnt_q;

endmodule

// File: rtl/filter_load_ctrl.sv
// Length-aware filter load sequencer: streams filter words into the scratchpad
// write port, then holds the loaded filter until the consumer releases it.
module filter_load_ctrl
  import filter_load_ctrl_pkg::*;
#(
  parameter int DATA_W     = FLC_DATA_W,
  parameter int SPAD_DEPTH = FLC_SPAD_DEPTH,
  parameter int ADDR_W     = FLC_ADDR_W
) (
  input logic              clk,
  input logic              rst,
  filter_load_ctrl_if.slave bus
);

  flc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              err_q, err_d;

  logic              len_ok;
  logic              hs;
  logic              cnt_clr;
  logic              cnt_tc;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] cnt_val;
  logic [ADDR_W-1:0] last_idx;

  assign len_ok   = flc_len_legal(32'(bus.filter_len), SPAD_DEPTH);
  assign hs       = bus.in_valid && (state_q == FLC_LOAD);
  assign last_idx = len_q - ADDR_W'(1);

  filter_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .en         (hs),
    .last_idx   (last_idx),
    .wr_ptr     (wr_ptr),
    .loaded_cnt (cnt_val),
    .tc         (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FLC_IDLE;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    err_d   = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      FLC_IDLE: begin
        if (bus.start) begin
          if (len_ok) begin
            len_d   = bus.filter_len;
            cnt_clr = 1'b1;
            state_d = FLC_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FLC_LOAD: begin
        if (hs && cnt_tc) begin
          state_d = FLC_LOADED;
        end
      end
      FLC_LOADED: begin
        // A start is only honoured together with release, giving back-to-back loads.
        if (bus.release_in) begin
          if (bus.start && len_ok) begin
            len_d   = bus.filter_len;
            cnt_clr = 1'b1;
            state_d = FLC_LOAD;
          end else begin
            err_d   = bus.start;
            state_d = FLC_IDLE;
          end
        end
      end
      default: begin
        state_d = FLC_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.in_ready     = (state_q == FLC_LOAD);
    bus.busy         = (state_q == FLC_LOAD);
    bus.filter_ready = (state_q == FLC_LOADED);
    bus.spad_wen     = hs;
    bus.spad_waddr   = {ADDR_W{1'b0}};
    bus.spad_wdata   = {DATA_W{1'b0}};
    if (state_q == FLC_LOAD) begin
      bus.spad_waddr = wr_ptr;
      bus.spad_wdata = bus.in_data;
    end
    bus.loaded_cnt = cnt_val;
    bus.err_len    = err_q;
  end

endmodule
